// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter. A packed NDIG-digit BCD word is
//   captured on an accepted start. One multiply-by-10-and-add step is then
//   done per clock, most significant digit first. A request holding any
//   digit above 9 is rejected in one clock with err set.
//
// Ports
//   clk     in   1        system clock, rising edge
//   rst_n   in   1        asynchronous active-low reset
//   start   in   1        conversion request, sampled only while idle
//   bcd_in  in   4*NDIG   packed BCD, top nibble = most significant digit
//   busy    out  1        conversion in progress
//   done    out  1        one-cycle pulse, val/err updated
//   val     out  WIDTH    binary result, holds until next done
//   err     out  1        last request contained a digit > 9
//
// Parameters
//   NDIG    number of BCD digits
//   WIDTH   result width, must satisfy 2^WIDTH > 10^NDIG - 1
// ---------------------------------------------------------------------------
module bcd_to_binary_seq #(
    parameter int NDIG  = 4,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*NDIG-1:0]     bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      val,
    output logic                  err
);

    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    acc_nx;
    logic [4*NDIG-1:0]   digits;
    logic                bad_in;
    logic                load;
    logic                reject;
    logic                step;
    logic                last;

    // True when any nibble of the word is outside 0..9.
    function automatic logic has_bad_digit(input logic [4*NDIG-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // acc*10 + d, with *10 formed as (acc<<3)+(acc<<1) at WIDTH+4 bits so the
    // intermediate cannot wrap, then truncated back to the result width.
    function automatic logic [WIDTH-1:0] mac10(input logic [WIDTH-1:0] a,
                                               input logic [3:0]       d);
        logic [WIDTH+3:0] ext;
        ext = {4'b0000, a};
        ext = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, d};
        return ext[WIDTH-1:0];
    endfunction

    assign bad_in = has_bad_digit(bcd_in);
    assign last   = (cnt == CNT_W'(NDIG - 1));
    // The captured word is shifted left each step, so the digit being folded
    // in is always the top nibble.
    assign acc_nx = mac10(acc, digits[4*NDIG-1 -: 4]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !bad_in) state_nx = CONV;
            CONV: if (last)             state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy   = (state == CONV);
        load   = (state == IDLE) && start && !bad_in;
        reject = (state == IDLE) && start &&  bad_in;
        step   = (state == CONV);
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            digits <= '0;
            val    <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                digits <= bcd_in;
                acc    <= '0;
                cnt    <= '0;
            end else if (reject) begin
                digits <= bcd_in;
                val    <= '0;
                err    <= 1'b1;
                done   <= 1'b1;
            end else if (step) begin
                acc    <= acc_nx;
                digits <= digits << 4;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    val  <= acc_nx;
                    err  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

    localparam int NDIG  = 4;
    localparam int WIDTH = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] bcd_in;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  val;
    logic              err;

    int checks;
    int failures;

    bcd_to_binary_seq #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .val    (val),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full conversion of a valid word: start driven for one clock, then every
    // cycle checked until the done pulse and one cycle beyond it.
    task automatic run_conv(input logic [15:0] b, input logic [15:0] expv,
                            input logic [15:0] prev_val, input string name);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);                       // after E0
        start  = 1'b0;
        bcd_in = 16'hFFFF;                    // must not matter once captured
        for (int k = 0; k < NDIG; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || val !== prev_val) begin
                failures++;
                $display("FAIL %s_busy%0d busy=%b done=%b val=%h required busy=1 done=0 val=%h",
                         name, k, busy, done, val, prev_val);
            end
        end
        @(negedge clk);                       // after E_NDIG
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || val !== expv || err !== 1'b0) begin
            failures++;
            $display("FAIL %s_done done=%b busy=%b val=%h err=%b required done=1 busy=0 val=%h err=0",
                     name, done, busy, val, err, expv);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || val !== expv) begin
            failures++;
            $display("FAIL %s_hold done=%b val=%h required done=0 val=%h", name, done, val, expv);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || val !== 16'h0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset busy=%b done=%b val=%h err=%b required all zero",
                     busy, done, val, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_conv(16'h1234, 16'h04D2, 16'h0000, "conv1234");
    endtask

    task automatic test_max_zero();
        run_conv(16'h9999, 16'h270F, 16'h04D2, "conv9999");
        run_conv(16'h0000, 16'h0000, 16'h270F, "conv0000");
    endtask

    task automatic test_bad_digit();
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h12A4;
        @(negedge clk);
        start  = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || val !== 16'h0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_digit done=%b err=%b val=%h busy=%b required done=1 err=1 val=0000 busy=0",
                     done, err, val, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL bad_digit_after done=%b busy=%b err=%b required done=0 busy=0 err=1",
                     done, busy, err);
        end
        run_conv(16'h0042, 16'h002A, 16'h0000, "conv0042");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0500;
        @(negedge clk);                       // after E0, start stays high
        bcd_in = 16'h0777;
        for (int k = 0; k < NDIG - 1; k++) begin
            @(negedge clk);                   // after E1..E3
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ignore%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
            end
        end
        @(negedge clk);                       // after E4: done cycle, start still high
        checks++;
        if (done !== 1'b1 || val !== 16'h01F4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first done=%b val=%h busy=%b required done=1 val=01f4 busy=0",
                     done, val, busy);
        end
        @(negedge clk);                       // after E5: second request accepted
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || val !== 16'h01F4) begin
            failures++;
            $display("FAIL b2b_accept busy=%b done=%b val=%h required busy=1 done=0 val=01f4",
                     busy, done, val);
        end
        repeat (NDIG - 1) @(negedge clk);     // after E6..E8
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_mid busy=%b done=%b required busy=1 done=0", busy, done);
        end
        @(negedge clk);                       // after E9
        checks++;
        if (done !== 1'b1 || val !== 16'h0309 || err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second done=%b val=%h err=%b required done=1 val=0309 err=0",
                     done, val, err);
        end
    endtask

    task automatic test_reset_abort();
        int saw_done;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h8888;
        @(negedge clk);                       // after E0
        start = 1'b0;
        @(negedge clk);                       // after E1
        @(negedge clk);                       // after E2
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || val !== 16'h0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_async busy=%b done=%b val=%h err=%b required all zero",
                     busy, done, val, err);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 0;
        for (int k = 0; k < NDIG + 2; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done != 0 || val !== 16'h0000) begin
            failures++;
            $display("FAIL abort_nodone activity=%0d val=%h required activity=0 val=0000",
                     saw_done, val);
        end
        run_conv(16'h0010, 16'h000A, 16'h0000, "conv0010");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_max_zero();
        test_bad_digit();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
